// File: rtl/data_decode.sv
// SEC Hamming decoder for 38-bit codewords: two-stage valid/ready pipeline
// (syndrome, then correct + extract) with saturating error counters.
module data_decode #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [37:0]          enc_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [5:0]           out_syndrome,
    output logic                 out_err_corr,
    output logic                 out_err_fatal,
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] fatal_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // XOR of the positions of all set bits equals the even-parity syndrome.
    function automatic logic [5:0] calc_syndrome(input logic [37:0] cw);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < 38; i++) begin
            s = s ^ (6'(i + 1) & {6{cw[i]}});
        end
        return s;
    endfunction

    function automatic logic [31:0] extract(input logic [37:0] cw);
        return {cw[37:32], cw[30:16], cw[14:8], cw[6:4], cw[2]};
    endfunction

    // Handshake: a word moves on a rising edge when valid and ready are both
    // high at that edge; a stage with valid=1 holds its contents until it can
    // advance. in_ready is combinational from out_ready through adv2/adv1.
    logic        v1;
    logic [37:0] s1_cw;
    logic [5:0]  s1_syn;
    logic        adv1;
    logic        adv2;

    assign adv2      = !out_valid || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            s1_cw  <= '0;
            s1_syn <= '0;
        end else if (adv1) begin
            v1     <= in_valid;
            s1_cw  <= enc_data;
            s1_syn <= calc_syndrome(enc_data);
        end
    end

    logic        syn_corr;
    logic        syn_fatal;
    logic [37:0] flip_mask;
    logic [37:0] fixed_cw;

    always_comb begin
        syn_corr  = (s1_syn != 6'd0) && (s1_syn <= 6'd38);
        syn_fatal = (s1_syn >= 6'd39);
        flip_mask = '0;
        if (syn_corr) begin
            flip_mask = 38'd1 << (s1_syn - 6'd1);
        end
        fixed_cw = s1_cw ^ flip_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_syndrome  <= '0;
            out_err_corr  <= 1'b0;
            out_err_fatal <= 1'b0;
        end else if (adv2) begin
            out_valid     <= v1;
            out_data      <= extract(fixed_cw);
            out_syndrome  <= s1_syn;
            out_err_corr  <= syn_corr;
            out_err_fatal <= syn_fatal;
        end
    end

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            corr_cnt  <= '0;
            fatal_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (out_err_corr && corr_cnt != CNT_MAX) begin
                corr_cnt <= corr_cnt + CNT_ONE;
            end
            if (out_err_fatal && fatal_cnt != CNT_MAX) begin
                fatal_cnt <= fatal_cnt + CNT_ONE;
            end
        end
    end

endmodule
